// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for the serial BCD subtractor.
// The master drives the request and operands; the slave returns status and result.
interface bcd_serial_subtractor_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   X;
    logic [4*DIGITS-1:0]   Y;
    logic                  b_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  negative;
    logic                  b_out;
    logic                  out_of_range;

    modport master (
        output start, X, Y, b_in,
        input  busy, done, result, negative, b_out, out_of_range
    );

    modport slave (
        input  start, X, Y, b_in,
        output busy, done, result, negative, b_out, out_of_range
    );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor computing X - Y - b_in as sign/magnitude.
// A negative raw difference is turned into its magnitude by a ten's-complement pass.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    bcd_serial_subtractor_if.slave  bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               borrow_q, borrow_d;
    logic [W-1:0]       x_q, x_d;
    logic [W-1:0]       y_q, y_d;
    logic [W-1:0]       result_q, result_d;
    logic               negative_q, negative_d;
    logic               b_out_q, b_out_d;
    logic               oor_q, oor_d;

    logic               digits_ok;
    logic [3:0]         x_dig, y_dig, r_dig;
    logic [3:0]         sub_a, sub_b, new_dig;
    logic [4:0]         diff;
    logic               last_dig;

    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.X[i*4 +: 4] > 4'd9 || bus.Y[i*4 +: 4] > 4'd9)
                digits_ok = 1'b0;
        end
    end

    // One shared digit subtractor: SUB uses X - Y, FIX uses 0 - raw result digit.
    always_comb begin
        x_dig = 4'd0;
        y_dig = 4'd0;
        r_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                x_dig = x_q[i*4 +: 4];
                y_dig = y_q[i*4 +: 4];
                r_dig = result_q[i*4 +: 4];
            end
        end
        sub_a    = (state_q == FIX) ? 4'd0 : x_dig;
        sub_b    = (state_q == FIX) ? r_dig : y_dig;
        diff     = {1'b0, sub_a} - {1'b0, sub_b} - {4'd0, borrow_q};
        new_dig  = diff[4] ? diff[3:0] + 4'd10 : diff[3:0];
        last_dig = (idx_q == IDX_W'(DIGITS - 1));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        borrow_d   = borrow_q;
        x_d        = x_q;
        y_d        = y_q;
        result_d   = result_q;
        negative_d = negative_q;
        b_out_d    = b_out_q;
        oor_d      = oor_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d        = bus.X;
                    y_d        = bus.Y;
                    result_d   = '0;
                    negative_d = 1'b0;
                    b_out_d    = 1'b0;
                    oor_d      = 1'b0;
                    if (!digits_ok) begin
                        oor_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d    = '0;
                        borrow_d = bus.b_in;
                        state_d  = SUB;
                    end
                end
            end
            SUB, FIX: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i))
                        result_d[i*4 +: 4] = new_dig;
                end
                borrow_d = diff[4];
                idx_d    = idx_q + IDX_W'(1);
                if (last_dig) begin
                    if (state_q == FIX) begin
                        state_d = DONE;
                    end else begin
                        b_out_d    = diff[4];
                        negative_d = diff[4];
                        if (diff[4]) begin
                            idx_d    = '0;
                            borrow_d = 1'b0;
                            state_d  = FIX;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            borrow_q   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            result_q   <= '0;
            negative_q <= 1'b0;
            b_out_q    <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            borrow_q   <= borrow_d;
            x_q        <= x_d;
            y_q        <= y_d;
            result_q   <= result_d;
            negative_q <= negative_d;
            b_out_q    <= b_out_d;
            oor_q      <= oor_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.result       = result_q;
    assign bus.negative     = negative_q;
    assign bus.b_out        = b_out_q;
    assign bus.out_of_range = oor_q;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for the serial BCD subtractor: a table of hand-computed
// vectors plus hand-written sequences for ignored starts and mid-operation reset.
module tb_bcd_serial_subtractor;
    localparam int DIGITS = 4;

    logic clk;
    logic reset;
    int   applied;
    int   errors;

    bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        bin;
        logic [15:0] res;
        logic        neg;
        logic        bout;
        logic        oor;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Caller is idle and #1 past a rising edge; returns with the DUT in its done cycle.
    task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y, input logic bin,
                                  output int lat, output logic busy_first);
        bus.X     = x;
        bus.Y     = y;
        bus.b_in  = bin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        busy_first = bus.busy;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int   lat;
        logic busy_first;
        int   done_seen;

        applied = 0;
        errors  = 0;

        vecs[0] = '{16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 1'b0, 5};
        vecs[1] = '{16'h0017, 16'h0042, 1'b0, 16'h0025, 1'b1, 1'b1, 1'b0, 9};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 9};
        vecs[3] = '{16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0, 5};
        vecs[4] = '{16'h00A1, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[5] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5};
        vecs[6] = '{16'h0000, 16'h9999, 1'b0, 16'h9999, 1'b1, 1'b1, 1'b0, 9};
        vecs[7] = '{16'h5000, 16'h0001, 1'b0, 16'h4999, 1'b0, 1'b0, 1'b0, 5};
        vecs[8] = '{16'h0100, 16'h000F, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[9] = '{16'h0999, 16'h1000, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 9};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.X     = '0;
        bus.Y     = '0;
        bus.b_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check_output("reset busy",     32'(bus.busy),         32'd0);
        check_output("reset done",     32'(bus.done),         32'd0);
        check_output("reset result",   32'(bus.result),       32'd0);
        check_output("reset negative", 32'(bus.negative),     32'd0);
        check_output("reset b_out",    32'(bus.b_out),        32'd0);
        check_output("reset oor",      32'(bus.out_of_range), 32'd0);

        for (int i = 0; i < 10; i++) begin
            $display("[TB] vector %0d: %h - %h - %0d", i, vecs[i].x, vecs[i].y, vecs[i].bin);
            apply_stimulus(vecs[i].x, vecs[i].y, vecs[i].bin, lat, busy_first);
            check_output("busy after start", 32'(busy_first),           32'd1);
            check_output("latency",          32'(lat),                  32'(vecs[i].lat));
            check_output("result",           32'(bus.result),           32'(vecs[i].res));
            check_output("negative",         32'(bus.negative),         32'(vecs[i].neg));
            check_output("b_out",            32'(bus.b_out),            32'(vecs[i].bout));
            check_output("out_of_range",     32'(bus.out_of_range),     32'(vecs[i].oor));
            @(posedge clk); #1;
            check_output("done one cycle",   32'(bus.done),             32'd0);
            check_output("idle after done",  32'(bus.busy),             32'd0);
            check_output("result held",      32'(bus.result),           32'(vecs[i].res));
        end

        // Start pulses while busy and during DONE must be ignored and not queued.
        $display("[TB] sequence: start while busy");
        bus.X = 16'h0042; bus.Y = 16'h0017; bus.b_in = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.X = 16'h0017; bus.Y = 16'h0042; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 3;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_output("busy-start latency",  32'(lat),          32'd5);
        check_output("busy-start result",   32'(bus.result),   32'h0025);
        check_output("busy-start negative", 32'(bus.negative), 32'd0);
        bus.X = 16'h0100; bus.Y = 16'h0000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_output("done-start busy",   32'(bus.busy),   32'd0);
        @(posedge clk); #1;
        check_output("done-start queued", 32'(bus.busy),   32'd0);
        check_output("done-start result", 32'(bus.result), 32'h0025);

        // Reset during the second SUB cycle aborts without a done pulse.
        $display("[TB] sequence: reset mid-operation");
        bus.X = 16'h0017; bus.Y = 16'h0042; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_output("abort busy",     32'(bus.busy),     32'd0);
        check_output("abort done",     32'(bus.done),     32'd0);
        check_output("abort result",   32'(bus.result),   32'd0);
        check_output("abort negative", 32'(bus.negative), 32'd0);
        check_output("abort b_out",    32'(bus.b_out),    32'd0);
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        check_output("abort no done", 32'(done_seen), 32'd0);
        apply_stimulus(16'h0017, 16'h0042, 1'b0, lat, busy_first);
        check_output("post-reset latency",  32'(lat),          32'd9);
        check_output("post-reset result",   32'(bus.result),   32'h0025);
        check_output("post-reset negative", 32'(bus.negative), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
